// File: rtl/sym_fir_pipe.sv
// Symmetric odd-length FIR: fold, multiply, adder tree, round/saturate.
// Coefficients are written into a shadow bank and copied to the active bank on coef_swap.
// Arithmetic stays full precision through the tree; only the output stage rounds and clips.
module sym_fir_pipe #(
  parameter  int DW    = 18,
  parameter  int CW    = 18,
  parameter  int NTAPS = 21,
  localparam int NH    = (NTAPS + 1) / 2,
  localparam int AW    = ($clog2(NH) < 1) ? 1 : $clog2(NH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] x_in,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 coef_swap,
  output logic                 swap_done,
  output logic                 out_valid,
  output logic signed [DW-1:0] y,
  output logic                 out_sat
);

  localparam int LV  = $clog2(NH);
  localparam int LAT = LV + 4;
  localparam int PW  = DW + 1;
  localparam int MW  = DW + 1 + CW;
  localparam int SW  = MW + LV;
  localparam int QW  = SW - CW + 1;

  // Node count of tree level l (level 0 holds the products).
  function automatic int lvl_n(input int l);
    int n;
    n = NH;
    for (int j = 0; j < l; j++) n = (n + 1) / 2;
    return n;
  endfunction

  // Flat index of the first node of tree level l.
  function automatic int lvl_off(input int l);
    int o;
    o = 0;
    for (int j = 0; j < l; j++) o += lvl_n(j);
    return o;
  endfunction

  localparam int NT = lvl_off(LV + 1);

  localparam logic signed [DW-1:0] YMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] YMIN = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW-1:0] r_x   [NTAPS];
  logic signed [PW-1:0] w_p   [NH];
  logic signed [PW-1:0] r_p   [NH];
  logic signed [CW-1:0] r_shd [NH];
  logic signed [CW-1:0] r_act [NH];
  logic signed [MW-1:0] w_m   [NH];
  logic signed [SW-1:0] w_nxt [NT];
  logic signed [SW-1:0] r_t   [NT];
  logic [LAT-1:0]       r_vld;
  logic                 r_swap_done;
  logic signed [DW-1:0] r_y;
  logic                 r_sat;

  // Delay line advances only on accepted samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) r_x[i] <= '0;
    end else if (in_valid) begin
      r_x[0] <= x_in;
      for (int i = 1; i < NTAPS; i++) r_x[i] <= r_x[i-1];
    end
  end

  for (genvar k = 0; k < NH; k++) begin : g_pre
    if (k < NH - 1) begin : g_fold
      assign w_p[k] = {r_x[k][DW-1], r_x[k]} + {r_x[NTAPS-1-k][DW-1], r_x[NTAPS-1-k]};
    end else begin : g_ctr
      assign w_p[k] = {r_x[k][DW-1], r_x[k]};
    end
    assign w_m[k] = $signed({{CW{r_p[k][PW-1]}}, r_p[k]})
                  * $signed({{PW{r_act[k][CW-1]}}, r_act[k]});
    assign w_nxt[k] = {{LV{w_m[k][MW-1]}}, w_m[k]};
  end

  // Tree level l node i sums two children of level l-1, or forwards an odd leftover.
  for (genvar l = 1; l <= LV; l++) begin : g_lvl
    for (genvar i = 0; i < lvl_n(l); i++) begin : g_node
      localparam int SRC = lvl_off(l - 1) + 2 * i;
      localparam int DST = lvl_off(l) + i;
      if (2 * i + 1 < lvl_n(l - 1)) begin : g_add
        assign w_nxt[DST] = r_t[SRC] + r_t[SRC+1];
      end else begin : g_pass
        assign w_nxt[DST] = r_t[SRC];
      end
    end
  end

  // Pre-add and product/tree registers run every cycle; validity travels separately.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NH; k++) r_p[k] <= '0;
      for (int i = 0; i < NT; i++) r_t[i] <= '0;
      r_vld <= '0;
    end else begin
      for (int k = 0; k < NH; k++) r_p[k] <= w_p[k];
      for (int i = 0; i < NT; i++) r_t[i] <= w_nxt[i];
      r_vld <= {r_vld[LAT-2:0], in_valid};
    end
  end

  // Shadow writes; swap copies shadow to active, forwarding a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NH; k++) begin
        r_shd[k] <= '0;
        r_act[k] <= '0;
      end
      r_swap_done <= 1'b0;
    end else begin
      for (int k = 0; k < NH; k++) begin
        if (coef_we && (coef_addr == AW'(k))) r_shd[k] <= coef_data;
        if (coef_swap) r_act[k] <= (coef_we && (coef_addr == AW'(k))) ? coef_data : r_shd[k];
      end
      r_swap_done <= coef_swap;
    end
  end

  // Round half up: floor(v / 2^CW) plus the first discarded bit.
  logic signed [SW-1:0] w_top;
  logic [QW-1:0]        w_q;
  logic [QW-DW:0]       w_hi;
  logic                 w_ovf;
  logic signed [DW-1:0] w_ysat;
  logic                 w_unused_lsb;

  assign w_top        = r_t[NT-1];
  assign w_q          = {w_top[SW-1], w_top[SW-1:CW]} + QW'(w_top[CW-1]);
  assign w_hi         = w_q[QW-1:DW-1];
  assign w_ovf        = ~((&w_hi) | ~(|w_hi));
  assign w_ysat       = w_ovf ? (w_q[QW-1] ? YMIN : YMAX) : w_q[DW-1:0];
  assign w_unused_lsb = ^w_top[CW-2:0];

  // Output register updates only when a valid sample leaves the tree, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y   <= '0;
      r_sat <= 1'b0;
    end else if (r_vld[LAT-2]) begin
      r_y   <= w_ysat;
      r_sat <= w_ovf;
    end
  end

  assign y         = r_y;
  assign out_sat   = r_sat;
  assign out_valid = r_vld[LAT-1];
  assign swap_done = r_swap_done;

endmodule

// File: tb/tb_sym_fir_pipe.sv
// Directed bench for sym_fir_pipe at default parameters (21 taps, latency 8).
module tb_sym_fir_pipe;
  localparam int DW = 18;
  localparam int CW = 18;
  localparam int AW = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic signed [DW-1:0] x_in;
  logic                 coef_we;
  logic [AW-1:0]        coef_addr;
  logic signed [CW-1:0] coef_data;
  logic                 coef_swap;
  logic                 swap_done;
  logic                 out_valid;
  logic signed [DW-1:0] y;
  logic                 out_sat;

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  sym_fir_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .coef_swap (coef_swap),
    .swap_done (swap_done),
    .out_valid (out_valid),
    .y         (y),
    .out_sat   (out_sat)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int d);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = CW'(d);
    tick();
    coef_we   = 1'b0;
  endtask

  task automatic do_swap();
    coef_swap = 1'b1;
    tick();
    coef_swap = 1'b0;
    chk("swap_done_pulse", swap_done, 1);
    tick();
    chk("swap_done_clear", swap_done, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic stream(input int v, input int n);
    in_valid = 1'b1;
    x_in     = DW'(v);
    repeat (n) tick();
    in_valid = 1'b0;
    x_in     = '0;
  endtask

  task automatic setup_imp();
    for (int k = 0; k < 11; k++) wr(k, 1024 * (k + 1));
    do_swap();
    tick();
  endtask

  // Impulse then 20 zeros, one sample every per cycles; outputs 256*(k+1) up to centre and back.
  task automatic run_imp(input int per);
    int   nin;
    int   nout;
    int   k;
    logic exp_v;
    logic vh[$];
    nin  = 0;
    nout = 0;
    for (int c = 0; c < 400 && nout < 21; c++) begin
      in_valid = (nin < 21) && (c % per == 0);
      x_in     = (in_valid && nin == 0) ? DW'(65536) : '0;
      if (in_valid) nin++;
      vh.push_back(in_valid);
      tick();
      exp_v = (c >= 7) ? vh[c-7] : 1'b0;
      chk("imp_valid", out_valid, exp_v);
      if (out_valid) begin
        k = (nout <= 10) ? nout : 20 - nout;
        chk("imp_y", y, 256 * (k + 1));
        chk("imp_sat", out_sat, 0);
        nout++;
      end
    end
    in_valid = 1'b0;
    x_in     = '0;
    chk("imp_count", nout, 21);
  endtask

  initial begin
    int bad;
    reset     = 1'b1;
    in_valid  = 1'b0;
    x_in      = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    coef_swap = 1'b0;
    tick();
    tick();
    chk("rst_y", y, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_sat", out_sat, 0);
    chk("rst_swap_done", swap_done, 0);
    reset = 1'b0;

    setup_imp();
    run_imp(1);

    do_reset();
    setup_imp();
    run_imp(3);

    // Rounding; writes to out-of-range addresses must not land anywhere.
    do_reset();
    wr(10, 2);
    wr(11, 131071);
    wr(15, 131071);
    do_swap();
    stream(65536, 30);
    chk("rnd_pos_valid", out_valid, 1);
    chk("rnd_pos_y", y, 1);
    chk("rnd_pos_sat", out_sat, 0);
    stream(-65536, 30);
    chk("rnd_neg_y", y, 0);
    wr(10, 1);
    do_swap();
    stream(131071, 30);
    chk("rnd_small_y", y, 0);

    // Saturation, with back-to-back swaps.
    for (int k = 0; k < 11; k++) wr(k, 131071);
    coef_swap = 1'b1;
    tick();
    chk("dbl_swap_1", swap_done, 1);
    tick();
    chk("dbl_swap_2", swap_done, 1);
    coef_swap = 1'b0;
    tick();
    chk("dbl_swap_end", swap_done, 0);
    stream(131071, 30);
    chk("sat_pos_y", y, 131071);
    chk("sat_pos_flag", out_sat, 1);
    stream(-131072, 30);
    chk("sat_neg_y", y, -131072);
    chk("sat_neg_flag", out_sat, 1);
    repeat (10) tick();
    chk("hold_valid", out_valid, 0);
    chk("hold_y", y, -131072);
    chk("hold_sat", out_sat, 1);

    // Coefficient swap while streaming.
    do_reset();
    wr(10, 4096);
    do_swap();
    in_valid = 1'b1;
    x_in     = DW'(65536);
    repeat (30) tick();
    chk("swp_base_y", y, 1024);
    chk("swp_base_sat", out_sat, 0);
    wr(10, 8192);
    repeat (15) tick();
    chk("swp_shadow_only_y", y, 1024);
    coef_we   = 1'b1;
    coef_addr = AW'(10);
    coef_data = CW'(8192);
    coef_swap = 1'b1;
    tick();
    coef_we   = 1'b0;
    coef_swap = 1'b0;
    chk("swp_done_pulse", swap_done, 1);
    chk("swp_old_y", y, 1024);
    tick();
    chk("swp_done_clear", swap_done, 0);
    repeat (6) tick();
    chk("swp_new_y", y, 2048);
    chk("swp_new_valid", out_valid, 1);
    repeat (3) tick();
    chk("swp_new_y_later", y, 2048);
    coef_we   = 1'b1;
    coef_addr = AW'(10);
    coef_data = CW'(12288);
    coef_swap = 1'b1;
    tick();
    coef_we   = 1'b0;
    coef_swap = 1'b0;
    repeat (9) tick();
    chk("swp_forward_y", y, 3072);

    // Reset mid-stream, with a swap request in the same cycle.
    reset     = 1'b1;
    coef_swap = 1'b1;
    tick();
    reset     = 1'b0;
    coef_swap = 1'b0;
    in_valid  = 1'b0;
    x_in      = '0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_sat", out_sat, 0);
    chk("mid_rst_swap_done", swap_done, 0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    chk("mid_rst_no_partial", bad, 0);
    stream(65536, 12);
    chk("mid_rst_bank_valid", out_valid, 1);
    chk("mid_rst_bank_clear_y", y, 0);
    do_reset();
    setup_imp();
    run_imp(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
